store_commit_ctrl: RTL
======================

# store_commit_ctrl

Sequencer that drains ROB-committed stores from the head of the store queue into the single data-memory port, sharing that port with the load path. It tracks how many head stores are architecturally committed, issues them one at a time with a request/acknowledge handshake, and pops the store queue on completion. Loads get priority unless store backlog or starvation forces a store grant. It sits between the ROB retire stage, the store queue head, the load unit and the D-cache/memory port.

## Interface
- N, 2, maximum stores the ROB can commit per cycle
- SQ_DEPTH, 8, store-queue depth; bounds the committed-store counter
- ADDR_W, 32, address width
- DATA_W, 32, store data width
- HIGH_WATER, 6, committed-store backlog at which stores override loads
- STARVE_LIMIT, 4, consecutive lost arbitrations after which a store is forced

- clock  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low; 0 = in reset
- rob_commit_stores  in  $clog2(N+1)  stores committed by ROB this cycle
- sq_head_valid  in  1  store-queue head entry valid
- sq_head_addr  in  ADDR_W  head store address
- sq_head_data  in  DATA_W  head store data
- sq_head_size  in  2  head store size (byte/half/word)
- sq_pop  out  1  one-cycle pulse: dequeue one head entry
- ld_req_valid  in  1  load requests memory port
- ld_req_addr  in  ADDR_W  load address
- ld_req_size  in  2  load size
- ld_req_ready  out  1  load accepted this cycle
- mem_req_valid  out  1  memory request valid (registered)
- mem_req_we  out  1  1 = store, 0 = load (registered)
- mem_req_addr  out  ADDR_W  registered
- mem_req_data  out  DATA_W  registered; 0 for loads
- mem_req_size  out  2  registered
- mem_req_ready  in  1  memory accepts request
- mem_st_ack  in  1  store write completed
- pending_cnt  out  $clog2(SQ_DEPTH+1)  committed, not-yet-written stores
- sq_drained  out  1  pending_cnt == 0 and FSM in IDLE
- overflow_err  out  1  sticky: commit would exceed SQ_DEPTH

## Operation
- States: IDLE, LD_REQ, ST_REQ, ST_ACK.
- store_eligible = (pending_cnt != 0) && sq_head_valid.
- force_store = (pending_cnt >= HIGH_WATER) || (starve_cnt == STARVE_LIMIT).
- IDLE: if store_eligible && (!ld_req_valid || force_store): latch head addr/data/size, we=1, mem_req_valid=1, go ST_REQ, clear starve_cnt. Else if ld_req_valid: ld_req_ready=1 (combinational, this cycle only), latch load fields, we=0, go LD_REQ; if store_eligible, starve_cnt increments (saturates at STARVE_LIMIT). Else stay.
- LD_REQ: hold request; on mem_req_ready, drop mem_req_valid, go IDLE.
- ST_REQ: hold request; on mem_req_ready, drop mem_req_valid, go ST_ACK.
- ST_ACK: on mem_st_ack, pulse sq_pop, go IDLE. Ack sampled only in ST_ACK.
- pending_cnt_next = pending_cnt + rob_commit_stores − sq_pop; commit and pop in same cycle both apply. If sum exceeds SQ_DEPTH: saturate at SQ_DEPTH, set overflow_err (cleared only by reset).
- ld_req_ready is never asserted outside IDLE.
- pending_cnt > 0 with sq_head_valid=0: no store issued; wait.

## Timing
- Reset (async assert, sync-safe deassert): state IDLE, all mem_req_* 0, sq_pop 0, ld_req_ready 0, pending_cnt 0, starve_cnt 0, sq_drained 1, overflow_err 0. Reset mid-transaction abandons request immediately.
- Store grant edge → mem_req_valid high next cycle; with ready=1 immediately and ack one cycle later, sq_pop pulses in cycle 3 after grant; next grant earliest cycle after pop. Max store throughput 1 per 3 cycles.
- Load: ld_req_ready in grant cycle, mem_req_valid next cycle, min 2 cycles per load.
- Commit becomes visible in pending_cnt the cycle after rob_commit_stores; earliest grant that cycle.
- mem_req_* fields stable while mem_req_valid=1 and ready=0.

## Test plan
- Reset then rob_commit_stores=2, head valid, no loads → two stores issued addr/data in order, sq_pop pulses twice, pending_cnt 2→1→0, sq_drained=1 after.
- Constant ld_req_valid, pending_cnt=1 → loads granted 4 times, 5th IDLE arbitration forces store (starve_cnt=STARVE_LIMIT).
- pending_cnt reaches 6 with ld_req_valid=1 → store granted immediately, ld_req_ready=0 that cycle.
- mem_req_ready held low 5 cycles in ST_REQ → request fields unchanged, no pop, no ld_req_ready.
- pending_cnt=7, rob_commit_stores=2, no pop → pending_cnt=8, overflow_err=1 and stays 1.
- Assert reset during ST_ACK → mem_req_valid=0, pending_cnt=0, IDLE same cycle; no sq_pop on later ack.

Source files
------------

// File: rtl/store_commit_ctrl_if.sv
// store_commit_ctrl_if: store-queue head, load request and memory port bundle
interface store_commit_ctrl_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              sq_head_valid;
    logic [ADDR_W-1:0] sq_head_addr;
    logic [DATA_W-1:0] sq_head_data;
    logic [1:0]        sq_head_size;
    logic              sq_pop;
    logic              ld_req_valid;
    logic [ADDR_W-1:0] ld_req_addr;
    logic [1:0]        ld_req_size;
    logic              ld_req_ready;
    logic              mem_req_valid;
    logic              mem_req_we;
    logic [ADDR_W-1:0] mem_req_addr;
    logic [DATA_W-1:0] mem_req_data;
    logic [1:0]        mem_req_size;
    logic              mem_req_ready;
    logic              mem_st_ack;

    modport slave (
        input  sq_head_valid, sq_head_addr, sq_head_data, sq_head_size,
        input  ld_req_valid, ld_req_addr, ld_req_size, mem_req_ready, mem_st_ack,
        output sq_pop, ld_req_ready, mem_req_valid, mem_req_we, mem_req_addr,
        output mem_req_data, mem_req_size
    );

    modport master (
        output sq_head_valid, sq_head_addr, sq_head_data, sq_head_size,
        output ld_req_valid, ld_req_addr, ld_req_size, mem_req_ready, mem_st_ack,
        input  sq_pop, ld_req_ready, mem_req_valid, mem_req_we, mem_req_addr,
        input  mem_req_data, mem_req_size
    );
endinterface

// File: rtl/store_commit_ctrl.sv
// store_commit_ctrl: drains committed stores to the shared memory port, arbitrating against loads
module store_commit_ctrl #(
    parameter int N            = 2,
    parameter int SQ_DEPTH     = 8,
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int HIGH_WATER   = 6,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [$clog2(N+1)-1:0]        rob_commit_stores_i,
    store_commit_ctrl_if.slave            bus,
    output logic [$clog2(SQ_DEPTH+1)-1:0] pending_cnt_o,
    output logic                          sq_drained_o,
    output logic                          overflow_err_o
);
    localparam int PW = $clog2(SQ_DEPTH + 1);
    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam logic [1:0] IDLE = 2'd0, LD_REQ = 2'd1, ST_REQ = 2'd2, ST_ACK = 2'd3;

    logic [1:0]        state_q, state_d;
    logic [PW-1:0]     pending_q, pending_d;
    logic [SW-1:0]     starve_q, starve_d;
    logic              ovf_q, ovf_d;
    logic              valid_q, valid_d, we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [1:0]        size_q, size_d;
    logic              store_eligible, force_store, grant_st, grant_ld, pop, over;
    logic [PW:0]       sum;

    assign store_eligible = (pending_q != '0) && bus.sq_head_valid;
    assign force_store    = (pending_q >= PW'(HIGH_WATER)) || (starve_q == SW'(STARVE_LIMIT));
    assign grant_st       = (state_q == IDLE) && store_eligible && (!bus.ld_req_valid || force_store);
    // gated by rst_n so a load is never accepted while the block is held in reset
    assign grant_ld       = rst_n && (state_q == IDLE) && !grant_st && bus.ld_req_valid;
    assign pop            = (state_q == ST_ACK) && bus.mem_st_ack;
    assign sum            = {1'b0, pending_q} + (PW+1)'(rob_commit_stores_i) - (PW+1)'(pop);
    assign over           = sum > (PW+1)'(SQ_DEPTH);
    assign pending_d      = over ? PW'(SQ_DEPTH) : sum[PW-1:0];
    assign ovf_d          = ovf_q | over;

    always_comb begin
        state_d  = state_q;
        valid_d  = valid_q;
        we_d     = we_q;
        addr_d   = addr_q;
        data_d   = data_q;
        size_d   = size_q;
        starve_d = starve_q;
        if (grant_st) begin
            state_d  = ST_REQ;
            valid_d  = 1'b1;
            we_d     = 1'b1;
            addr_d   = bus.sq_head_addr;
            data_d   = bus.sq_head_data;
            size_d   = bus.sq_head_size;
            starve_d = '0;
        end else if (grant_ld) begin
            state_d  = LD_REQ;
            valid_d  = 1'b1;
            we_d     = 1'b0;
            addr_d   = bus.ld_req_addr;
            data_d   = '0;
            size_d   = bus.ld_req_size;
            starve_d = (store_eligible && starve_q != SW'(STARVE_LIMIT)) ? starve_q + 1'b1 : starve_q;
        end else if ((state_q == LD_REQ || state_q == ST_REQ) && bus.mem_req_ready) begin
            valid_d = 1'b0;
            state_d = (state_q == ST_REQ) ? ST_ACK : IDLE;
        end else if (pop) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            pending_q <= '0;
            starve_q  <= '0;
            ovf_q     <= 1'b0;
            valid_q   <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            data_q    <= '0;
            size_q    <= '0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            starve_q  <= starve_d;
            ovf_q     <= ovf_d;
            valid_q   <= valid_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            size_q    <= size_d;
        end
    end

    assign bus.sq_pop        = pop;
    assign bus.ld_req_ready  = grant_ld;
    assign bus.mem_req_valid = valid_q;
    assign bus.mem_req_we    = we_q;
    assign bus.mem_req_addr  = addr_q;
    assign bus.mem_req_data  = data_q;
    assign bus.mem_req_size  = size_q;
    assign pending_cnt_o     = pending_q;
    assign sq_drained_o      = (pending_q == '0) && (state_q == IDLE);
    assign overflow_err_o    = ovf_q;
endmodule
